// File: rtl/buzzer_scheduler.sv
// Round-robin time-share of NREQ buzzer lines: ON_CYCLES on per grant, then GAP_CYCLES silent.
// Latency req->buzz is one cycle from idle; enable low aborts the active grant and holds off new ones.
module buzzer_scheduler #(
  parameter int NREQ       = 3,
  parameter int ON_CYCLES  = 31,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] buzz,
  output logic [NREQ-1:0] pending,
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NREQ - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  pending_q, pending_d;
  logic [NREQ-1:0]  buzz_q, buzz_d;
  logic             done_q, done_d;

  logic [NREQ-1:0]  active, eff_req, cand, sel_oh;
  logic [PTR_W-1:0] sel, idx;
  logic             found, grant;

  // The channel currently sounding ignores its own request: it is merged into the grant.
  assign active  = (state_q == S_ON) ? buzz_q : '0;
  assign eff_req = req & ~active;
  assign cand    = pending_q | eff_req;

  always_comb begin
    sel    = rr_ptr_q;
    found  = 1'b0;
    idx    = '0;
    sel_oh = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    sel_oh[sel] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    buzz_d   = buzz_q;
    grant    = 1'b0;
    case (state_q)
      S_IDLE: grant = enable && found;
      S_ON: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          buzz_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_CYCLES == 0) begin
          grant   = found;
          state_d = S_IDLE;
          buzz_d  = '0;
        end else begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
          buzz_d  = '0;
        end
      end
      S_GAP: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          grant   = found;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        buzz_d  = '0;
      end
    endcase
    if (grant) begin
      state_d  = S_ON;
      cnt_d    = ON_LOAD;
      buzz_d   = sel_oh;
      rr_ptr_d = sel;
    end
    // A grant clears only its own channel; new requests on others still latch.
    pending_d = cand & ~(grant ? sel_oh : '0);
    done_d    = (state_d == S_ON) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rr_ptr_q  <= PTR_RST;
      pending_q <= '0;
      buzz_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      buzz_q    <= buzz_d;
      done_q    <= done_d;
    end
  end

  assign buzz    = buzz_q;
  assign pending = pending_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Bench for buzzer_scheduler: grant-level reference model checked every cycle, plus directed literal scenarios.
module tb_buzzer_scheduler;
  localparam int NREQ = 3;
  localparam int ON   = 31;
  localparam int GAP  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] buzz, pending;
  logic            busy, done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  buzzer_scheduler #(.NREQ(NREQ), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .buzz(buzz), .pending(pending), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: which channel sounds, how many on/gap cycles remain, who was granted last.
  int m_chan = -1;
  int m_on_left = 0;
  int m_gap_left = 0;
  int m_last = NREQ - 1;
  logic [NREQ-1:0] m_pend = '0;

  function automatic void model_reset();
    m_chan = -1; m_on_left = 0; m_gap_left = 0; m_last = NREQ - 1; m_pend = '0;
  endfunction

  function automatic void model_step();
    logic [NREQ-1:0] c;
    bit can_grant;
    bit got;
    int idx;
    can_grant = 1'b0;
    got = 1'b0;
    for (int i = 0; i < NREQ; i++) c[i] = m_pend[i] | (req[i] && (i != m_chan));
    m_pend = c;
    if (m_chan >= 0) begin
      if (!enable) m_chan = -1;
      else if (m_on_left > 1) m_on_left--;
      else begin
        m_chan = -1;
        if (GAP == 0) can_grant = 1'b1;
        else m_gap_left = GAP;
      end
    end else if (m_gap_left > 0) begin
      if (!enable) m_gap_left = 0;
      else if (m_gap_left > 1) m_gap_left--;
      else begin
        m_gap_left = 0;
        can_grant = 1'b1;
      end
    end else begin
      can_grant = enable;
    end
    if (can_grant) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (!got && c[idx]) begin
          got = 1'b1;
          m_chan = idx;
          m_on_left = ON;
          m_last = idx;
          m_pend[idx] = 1'b0;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [NREQ-1:0] eb;
    if (chk_en) begin
      eb = '0;
      if (m_chan >= 0) eb[m_chan] = 1'b1;
      chk("model_buzz", 32'(buzz), 32'(eb));
      chk("model_pending", 32'(pending), 32'(m_pend));
      chk("model_busy", 32'(busy), 32'((m_chan >= 0) || (m_gap_left > 0)));
      chk("model_done", 32'(done), 32'((m_chan >= 0) && (m_on_left == 1)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset held with all requests asserted.
    tick(1);
    chk_en = 1'b1;
    req = 3'b111;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_buzz", 32'(buzz), 32'h0);
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
    end
    req = '0;
    rst_n = 1'b1;
    tick(1);

    // Single one-cycle request on channel 1.
    req = 3'b010;
    tick(1);
    req = '0;
    chk("single_first", 32'(buzz), 32'h2);
    chk("single_busy", 32'(busy), 32'h1);
    tick(30);
    chk("single_last", 32'(buzz), 32'h2);
    chk("single_done", 32'(done), 32'h1);
    tick(1);
    chk("single_gap_buzz", 32'(buzz), 32'h0);
    chk("single_gap_busy", 32'(busy), 32'h1);
    chk("single_gap_done", 32'(done), 32'h0);
    tick(4);
    chk("single_idle", 32'(busy), 32'h0);

    // Async reset in the middle of a grant with a second request pending.
    req = 3'b101;
    tick(1);
    req = '0;
    chk("ar_grant", 32'(buzz), 32'h4);
    chk("ar_pend", 32'(pending), 32'h1);
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_buzz", 32'(buzz), 32'h0);
    chk("ar_pending", 32'(pending), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Simultaneous requests one cycle after reset.
    req = 3'b111;
    tick(1);
    req = '0;
    chk("sim_g0", 32'(buzz), 32'h1);
    chk("sim_p0", 32'(pending), 32'h6);
    tick(34);
    chk("sim_gap0", 32'(buzz), 32'h0);
    tick(1);
    chk("sim_g1", 32'(buzz), 32'h2);
    chk("sim_p1", 32'(pending), 32'h4);
    tick(35);
    chk("sim_g2", 32'(buzz), 32'h4);
    chk("sim_p2", 32'(pending), 32'h0);
    tick(40);
    chk("sim_idle", 32'(busy), 32'h0);

    // Fairness: req[0] held, req[2] pulsed once.
    req = 3'b101;
    tick(1);
    req = 3'b001;
    chk("fair_0", 32'(buzz), 32'h1);
    tick(35);
    chk("fair_1", 32'(buzz), 32'h4);
    tick(35);
    chk("fair_2", 32'(buzz), 32'h1);
    tick(35);
    chk("fair_3", 32'(buzz), 32'h1);
    req = '0;
    tick(40);
    chk("fair_idle", 32'(busy), 32'h0);

    // Abort on the 10th ON cycle of a channel-1 grant.
    req = 3'b010;
    tick(1);
    req = '0;
    chk("ab_grant", 32'(buzz), 32'h2);
    tick(2);
    req = 3'b001;
    tick(1);
    req = '0;
    tick(6);
    chk("ab_tenth", 32'(buzz), 32'h2);
    enable = 1'b0;
    tick(1);
    chk("ab_buzz", 32'(buzz), 32'h0);
    chk("ab_done", 32'(done), 32'h0);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_pend", 32'(pending), 32'h1);
    tick(3);
    chk("ab_hold", 32'(buzz), 32'h0);
    enable = 1'b1;
    tick(1);
    chk("ab_resume", 32'(buzz), 32'h1);
    chk("ab_pend_clr", 32'(pending), 32'h0);

    // Randomized traffic: sparse requests, occasional enable drops.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) req[i] = ($urandom_range(19) == 0);
      enable = ($urandom_range(39) != 0);
      tick(1);
    end
    req = '0;
    enable = 1'b1;
    tick(120);
    chk("end_idle", 32'(busy), 32'h0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
